// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder slice.
// Holds the default data/address widths, the write-counter width and the
// FSM state encoding. Other files pull these in with an import.
package mem_responder_pkg;

  localparam int unsigned DefaultDw = 16;
  localparam int unsigned DefaultAw = 6;
  localparam int unsigned CountW    = 8;

  typedef enum logic [1:0] {
    StInit = 2'b00,
    StIdle = 2'b01,
    StResp = 2'b10
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus of the memory responder.
//   read, write   : request strobes, sampled on each rising clock edge
//   addr, data_in : word address and write data
//   data_out      : registered read data, held between reads
//   rd_valid      : one-cycle pulse marking data_out as freshly read
//   busy          : high while the post-reset clear sweep runs
//   err           : sticky error flag
//   wr_count      : count of committed writes, wraps at 255 -> 0
// modport master is the requester side; modport slave is the responder.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned AW = DefaultAw
) ();

  logic              read;
  logic              write;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     data_in;
  logic [DW-1:0]     data_out;
  logic              rd_valid;
  logic              busy;
  logic              err;
  logic [CountW-1:0] wr_count;

  modport master (
    output read, write, addr, data_in,
    input  data_out, rd_valid, busy, err, wr_count
  );

  modport slave (
    input  read, write, addr, data_in,
    output data_out, rd_valid, busy, err, wr_count
  );

endinterface

// File: rtl/mem_array.sv
// Single-port storage array: synchronous write, combinational read.
//   clk   : clock
//   we    : write enable, commits wdata to mem[addr] on the rising edge
//   addr  : shared read/write word address
//   wdata : write data
//   rdata : combinational read of mem[addr]
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned AW = DefaultAw
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: after reset, clears every word (busy high), then
// serves single-cycle-latency reads and writes over the bus interface.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : slave side of mem_responder_if (requests in, response/status out)
// A simultaneous read+write commits the write, drops the read and sets err.
// Any request while busy is ignored and sets err.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned AW = DefaultAw
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam logic [AW-1:0] SweepLast = '1;

  state_e            state_q;
  logic [AW-1:0]     sweep_q;
  logic [DW-1:0]     data_out_q;
  logic              rd_valid_q;
  logic              err_q;
  logic [CountW-1:0] wr_count_q;

  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  // The sweep owns the single array port while clearing; otherwise the bus
  // address drives it for both reads and writes.
  always_comb begin
    mem_we    = bus.write;
    mem_addr  = bus.addr;
    mem_wdata = bus.data_in;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_addr  = sweep_q;
      mem_wdata = '0;
    end
  end

  mem_array #(
    .DW (DW),
    .AW (AW)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      sweep_q    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      wr_count_q <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        StInit: begin
          if (bus.read || bus.write) begin
            err_q <= 1'b1;
          end
          sweep_q <= sweep_q + AW'(1);
          if (sweep_q == SweepLast) begin
            state_q <= StIdle;
          end
        end
        StIdle, StResp: begin
          if (bus.write) begin
            wr_count_q <= wr_count_q + CountW'(1);
            if (bus.read) begin
              err_q <= 1'b1;
            end
            state_q <= StIdle;
          end else if (bus.read) begin
            data_out_q <= mem_rdata;
            rd_valid_q <= 1'b1;
            state_q    <= StResp;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state_q == StInit);
  assign bus.err      = err_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder.
module tb_mem_responder;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 6;

  logic clk;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;
  int cnt;

  mem_responder_if #(.DW(DW), .AW(AW)) bus ();

  mem_responder #(
    .DW (DW),
    .AW (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs set after this are stable for
  // the following edge and outputs read here reflect the edge just taken.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bus.read    = rd;
    bus.write   = wr;
    bus.addr    = a;
    bus.data_in = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);

    // Reset values
    tick();
    tick();
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("rst_err",      32'(bus.err),      32'h0);
    check("rst_wr_count", 32'(bus.wr_count), 32'h0);
    check("rst_busy",     32'(bus.busy),     32'h1);

    // Sweep interrupted by reset at cycle 30
    rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("mid_sweep_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    tick();
    tick();
    check("mid_rst_busy", 32'(bus.busy), 32'h1);
    rst = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      tick();
    end
    check("busy_cycles", 32'(cnt), 32'd64);
    check("sweep_err",   32'(bus.err), 32'h0);

    // Sweep reached the top address
    drive(1'b1, 1'b0, 6'd63, '0);
    tick();
    check("rd63_valid", 32'(bus.rd_valid), 32'h1);
    check("rd63_data",  32'(bus.data_out), 32'h0);
    drive(1'b0, 1'b0, '0, '0);
    tick();
    check("rd63_pulse_end", 32'(bus.rd_valid), 32'h0);

    // Basic write then read
    drive(1'b0, 1'b1, 6'd5, 16'hBEEF);
    tick();
    check("wr5_count", 32'(bus.wr_count), 32'd1);
    check("wr5_no_valid", 32'(bus.rd_valid), 32'h0);
    drive(1'b1, 1'b0, 6'd5, '0);
    tick();
    check("rd5_data",  32'(bus.data_out), 32'hBEEF);
    check("rd5_valid", 32'(bus.rd_valid), 32'h1);
    drive(1'b0, 1'b0, '0, '0);
    tick();
    check("rd5_pulse_end", 32'(bus.rd_valid), 32'h0);
    check("rd5_hold",      32'(bus.data_out), 32'hBEEF);
    check("rd5_err",       32'(bus.err),      32'h0);

    // Collision: write wins, read dropped, err set
    drive(1'b1, 1'b1, 6'd9, 16'h1234);
    tick();
    check("coll_valid", 32'(bus.rd_valid), 32'h0);
    check("coll_err",   32'(bus.err),      32'h1);
    check("coll_count", 32'(bus.wr_count), 32'd2);
    check("coll_hold",  32'(bus.data_out), 32'hBEEF);
    drive(1'b1, 1'b0, 6'd9, '0);
    tick();
    check("rd9_data",  32'(bus.data_out), 32'h1234);
    check("rd9_valid", 32'(bus.rd_valid), 32'h1);

    // Write accepted while in RESP (read of 9 above left it there)
    drive(1'b0, 1'b1, 6'd1, 16'h1111);
    tick();
    check("resp_wr_count", 32'(bus.wr_count), 32'd3);
    check("resp_wr_valid", 32'(bus.rd_valid), 32'h0);
    drive(1'b0, 1'b1, 6'd2, 16'h2222);
    tick();
    drive(1'b0, 1'b1, 6'd3, 16'h3333);
    tick();
    check("wr3_count", 32'(bus.wr_count), 32'd5);

    // Back-to-back reads
    drive(1'b1, 1'b0, 6'd1, '0);
    tick();
    check("stream1_valid", 32'(bus.rd_valid), 32'h1);
    check("stream1_data",  32'(bus.data_out), 32'h1111);
    drive(1'b1, 1'b0, 6'd2, '0);
    tick();
    check("stream2_valid", 32'(bus.rd_valid), 32'h1);
    check("stream2_data",  32'(bus.data_out), 32'h2222);
    drive(1'b1, 1'b0, 6'd3, '0);
    tick();
    check("stream3_valid", 32'(bus.rd_valid), 32'h1);
    check("stream3_data",  32'(bus.data_out), 32'h3333);
    drive(1'b0, 1'b0, '0, '0);
    tick();
    check("stream_end", 32'(bus.rd_valid), 32'h0);

    // Counter wrap: 5 + 250 = 255, one more wraps to 0
    for (int i = 0; i < 250; i++) begin
      drive(1'b0, 1'b1, 6'd10, 16'(i));
      tick();
    end
    check("count_255", 32'(bus.wr_count), 32'd255);
    drive(1'b0, 1'b1, 6'd10, 16'hA5A5);
    tick();
    check("count_wrap", 32'(bus.wr_count), 32'd0);
    drive(1'b1, 1'b0, 6'd10, '0);
    tick();
    check("rd10_data", 32'(bus.data_out), 32'hA5A5);

    // Reset alongside a read: no response, everything cleared
    rst = 1'b1;
    tick();
    check("rst_rd_drop", 32'(bus.rd_valid), 32'h0);
    drive(1'b0, 1'b0, '0, '0);
    tick();
    check("rst2_err",      32'(bus.err),      32'h0);
    check("rst2_count",    32'(bus.wr_count), 32'h0);
    check("rst2_data_out", 32'(bus.data_out), 32'h0);

    // Access during busy, after address 0 has already been cleared
    rst = 1'b0;
    tick();
    tick();
    tick();
    drive(1'b0, 1'b1, 6'd0, 16'hFFFF);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    check("busy_wr_err",   32'(bus.err),      32'h1);
    check("busy_wr_count", 32'(bus.wr_count), 32'h0);
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      tick();
    end
    check("busy_done", 32'(bus.busy), 32'h0);
    drive(1'b1, 1'b0, 6'd0, '0);
    tick();
    check("rd0_valid", 32'(bus.rd_valid), 32'h1);
    check("rd0_data",  32'(bus.data_out), 32'h0);
    check("err_sticky", 32'(bus.err),     32'h1);
    drive(1'b0, 1'b0, '0, '0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
